jk_counter: RTL and testbench
=============================

JK_COUNTER -- requirements
Module: jk_counter

Interface
REQ-001 Parameter WIDTH, default 4, sets the counter bit width (legal range 2..16).
REQ-002 Parameter MODULUS, default 10, sets the count sequence to 0..MODULUS-1 (legal range 2..2^WIDTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count/load enable; en=0 means hold regardless of mode.
REQ-006 mode  input  2  operation: 00 hold, 01 up, 10 down, 11 load.
REQ-007 d  input  WIDTH  load value, sampled when en=1 and mode=11.
REQ-008 q  output  WIDTH  current count.
REQ-009 q_  output  WIDTH  bitwise complement of q at all times, including during reset.
REQ-010 tc  output  1  terminal count, combinational: (mode=01 and q=MODULUS-1) or (mode=10 and q=0), gated by en.
REQ-011 carry  output  1  registered one-cycle pulse in the cycle after a wrap (or saturation hit, see REQ-024).
REQ-012 err  output  1  registered one-cycle pulse in the cycle after an out-of-range load.

Function
REQ-013 Each count bit SHALL be held in a jk_ff instance, with J = next & ~q and K = ~next & q per bit.
REQ-014 Hold (en=0 or mode=00): J=K=0 on every bit; q, carry and err SHALL be unchanged, apart from carry and err returning to 0.
REQ-015 Up: q becomes q+1, and from MODULUS-1 it becomes 0 with carry=1 in the following cycle.
REQ-016 Down: q becomes q-1, and from 0 it becomes MODULUS-1 with carry=1 in the following cycle.
REQ-017 Load with d<MODULUS: q becomes d, and carry=0, err=0.
REQ-018 Load with d>=MODULUS: q becomes MODULUS-1 and err=1 for exactly one cycle.
REQ-019 Latency: one clock edge from input to q, carry and err; tc has zero latency.
REQ-020 The next-state arithmetic SHALL be done in WIDTH+1 bits so no intermediate overflow occurs when MODULUS=2^WIDTH.
REQ-021 Mode or en changes take effect on the next edge only; no internal mode state is retained.

Reset
REQ-022 reset=1 SHALL immediately force q=0, q_=all-ones, carry=0 and err=0, independent of clk, including mid-operation.
REQ-023 On reset deassertion, the first rising edge with reset=0 SHALL perform the normal operation selected by en and mode.

Configuration
REQ-024 With macro JK_COUNTER_SAT_EN defined, up at MODULUS-1 and down at 0 SHALL hold q (saturate) and pulse carry.
REQ-025 Without JK_COUNTER_SAT_EN, the counter wraps as in REQ-015/016; all other behaviour is identical in both builds.

Structure
REQ-026 Package jk_counter_pkg SHALL hold the mode typedef (MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11).
REQ-027 The per-bit storage SHALL be sub-module jk_ff (ports clk, reset, j, k, q, q_), instantiated WIDTH times via generate.
REQ-028 jk_ff SHALL follow the JK truth table: 00 hold, 01 reset, 10 set, 11 toggle; reset forces q=0.

Verification (WIDTH=4, MODULUS=10)
REQ-029 Reset then en=1, mode=01 for 12 edges -> q=1..9,0,1,2; carry=1 only in the cycle after 9->0; tc=1 while q=9.
REQ-030 Load d=7, then mode=10 for 9 edges -> q=7,6..0,9,8; carry pulses after 0->9; tc=1 while q=0.
REQ-031 Load d=12 -> q=9, err=1 for one cycle; then load d=3 -> q=3, err=0.
REQ-032 Counting at q=5, assert reset between edges -> q=0 and q_=4'b1111 before the next edge; release -> counting resumes from 0.
REQ-033 en=0 with mode=01 for 5 edges at q=4 -> q stays 4, tc=0, carry=0.
REQ-034 JK_COUNTER_SAT_EN build: up from 8 for 3 edges -> q=9,9,9; carry pulses; down from 0 -> q stays 0.

Source files
------------

// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-flip-flop based modulo counter.
// The mode encoding is fixed and is used by the counter and its testbench.
package jk_counter_pkg;

    // Counter operation selected by the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // J/K drive for one bit so that the flop moves from cur to nxt.
    function automatic logic [1:0] jk_drive(input logic cur, input logic nxt);
        return {nxt & ~cur, ~nxt & cur};
    endfunction

endpackage : jk_counter_pkg

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-high reset.
// Truth table on {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_ff (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_
);

    logic state_q;

    // Stored bit follows the JK truth table; reset clears it immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   state_q <= state_q;
                2'b01:   state_q <= 1'b0;
                2'b10:   state_q <= 1'b1;
                default: state_q <= ~state_q;
            endcase
        end
    end

    assign q  = state_q;
    assign q_ = ~state_q;

endmodule : jk_ff

// File: rtl/jk_counter.sv
// Modulo-MODULUS up/down/load counter whose bits are stored in jk_ff cells.
// Optional build macro JK_COUNTER_SAT_EN: up at MODULUS-1 and down at 0
// saturate (hold q) instead of wrapping; carry still pulses on those hits.
module jk_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic             tc,
    output logic             carry,
    output logic             err
);

    import jk_counter_pkg::*;

    // Arithmetic is one bit wider so MODULUS = 2^WIDTH is representable.
    localparam int               W1      = WIDTH + 1;
    localparam logic [WIDTH:0]   MOD_EXT = W1'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = W1'(MODULUS - 1);

    mode_e            mode_s;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH-1:0] next_d;
    logic             carry_d;
    logic             err_d;
    logic             carry_q;
    logic             err_q;
    logic [WIDTH-1:0] j_bits;
    logic [WIDTH-1:0] k_bits;

    assign mode_s  = mode_e'(mode);
    assign q_ext   = {1'b0, q};
    assign d_ext   = {1'b0, d};
    assign up_sum  = q_ext + 1'b1;
    // A borrow into the extra bit marks the 0 -> MODULUS-1 wrap.
    assign dn_diff = q_ext - 1'b1;

    // Next count plus the carry/err pulses that the coming edge will register.
    always_comb begin
        next_d  = q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            case (mode_s)
                MODE_UP: begin
                    if (up_sum == MOD_EXT) begin
                        carry_d = 1'b1;
`ifdef JK_COUNTER_SAT_EN
                        next_d  = q;
`else
                        next_d  = '0;
`endif
                    end else begin
                        next_d = up_sum[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (dn_diff[WIDTH]) begin
                        carry_d = 1'b1;
`ifdef JK_COUNTER_SAT_EN
                        next_d  = q;
`else
                        next_d  = MAX_EXT[WIDTH-1:0];
`endif
                    end else begin
                        next_d = dn_diff[WIDTH-1:0];
                    end
                end
                MODE_LOAD: begin
                    if (d_ext >= MOD_EXT) begin
                        err_d  = 1'b1;
                        next_d = MAX_EXT[WIDTH-1:0];
                    end else begin
                        next_d = d;
                    end
                end
                default: begin
                    next_d = q;
                end
            endcase
        end
    end

    // Per-bit J/K so each flop moves from its current value to next_d.
    always_comb begin
        j_bits = '0;
        k_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_bits[i], k_bits[i]} = jk_drive(q[i], next_d[i]);
        end
    end

    // One-cycle carry and err pulses, cleared at once by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            jk_ff u_jk_ff (
                .clk   (clk),
                .reset (reset),
                .j     (j_bits[g]),
                .k     (k_bits[g]),
                .q     (q[g]),
                .q_    (q_[g])
            );
        end
    endgenerate

    // Terminal count looks at the live inputs, so it has no latency.
    assign tc = en & (((mode_s == MODE_UP)   && (q_ext == MAX_EXT)) ||
                      ((mode_s == MODE_DOWN) && (q == '0)));

    assign carry = carry_q;
    assign err   = err_q;

endmodule : jk_counter

// File: tb/tb_jk_counter.sv
// Directed testbench for jk_counter with WIDTH=4, MODULUS=10.
// Honours JK_COUNTER_SAT_EN: wrap checks in the default build,
// saturation checks when the macro is defined.
module tb_jk_counter;

    import jk_counter_pkg::*;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_;
    logic             tc;
    logic             carry;
    logic             err;

    int n_cmp;
    int n_err;

    jk_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .q     (q),
        .q_    (q_),
        .tc    (tc),
        .carry (carry),
        .err   (err)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks q, its complement, carry and err together.
    task automatic chk_state(input string tag, input logic [3:0] eq,
                             input logic ec, input logic ee);
        logic [3:0] enq;
        enq = ~eq;
        chk({tag, ".q"},     16'(q),     16'(eq));
        chk({tag, ".q_"},    16'(q_),    16'(enq));
        chk({tag, ".carry"}, 16'(carry), 16'(ec));
        chk({tag, ".err"},   16'(err),   16'(ee));
    endtask

    int up_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_q [9]  = '{6, 5, 4, 3, 2, 1, 0, 9, 8};

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        en    = 1'b0;
        mode  = MODE_HOLD;
        d     = '0;

        // Reset state, observed before any clock edge.
        #1;
        chk_state("reset", 4'd0, 1'b0, 1'b0);
        chk("reset.tc", 16'(tc), 16'd0);
        tick();
        chk_state("reset_edge", 4'd0, 1'b0, 1'b0);

        // Release reset away from an edge, then count up.
        reset = 1'b0;
        en    = 1'b1;
        mode  = MODE_UP;
        #1;
        chk("up0.tc", 16'(tc), 16'd0);

`ifndef JK_COUNTER_SAT_EN
        // Up count through the 9 -> 0 wrap.
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_state($sformatf("up%0d", i + 1), 4'(up_q[i]), (i == 9), 1'b0);
            chk($sformatf("up%0d.tc", i + 1), 16'(tc), 16'(up_q[i] == 9));
        end

        // Load 7 then count down through the 0 -> 9 wrap.
        mode = MODE_LOAD;
        d    = 4'd7;
        tick();
        chk_state("ld7", 4'd7, 1'b0, 1'b0);
        mode = MODE_DOWN;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_state($sformatf("dn%0d", i + 1), 4'(dn_q[i]), (i == 7), 1'b0);
            chk($sformatf("dn%0d.tc", i + 1), 16'(tc), 16'(dn_q[i] == 0));
        end
`else
        // Saturating build: up from 8 sticks at 9 with carry on each hit.
        mode = MODE_LOAD;
        d    = 4'd8;
        tick();
        chk_state("sat_ld8", 4'd8, 1'b0, 1'b0);
        mode = MODE_UP;
        tick();
        chk_state("sat_up1", 4'd9, 1'b0, 1'b0);
        chk("sat_up1.tc", 16'(tc), 16'd1);
        tick();
        chk_state("sat_up2", 4'd9, 1'b1, 1'b0);
        tick();
        chk_state("sat_up3", 4'd9, 1'b1, 1'b0);
        mode = MODE_LOAD;
        d    = 4'd0;
        tick();
        chk_state("sat_ld0", 4'd0, 1'b0, 1'b0);
        mode = MODE_DOWN;
        #1;
        chk("sat_dn.tc", 16'(tc), 16'd1);
        tick();
        chk_state("sat_dn1", 4'd0, 1'b1, 1'b0);
        tick();
        chk_state("sat_dn2", 4'd0, 1'b1, 1'b0);
`endif

        // Out-of-range and boundary loads.
        mode = MODE_LOAD;
        d    = 4'd12;
        tick();
        chk_state("ld12", 4'd9, 1'b0, 1'b1);
        d = 4'd3;
        tick();
        chk_state("ld3", 4'd3, 1'b0, 1'b0);
        d = 4'd10;
        tick();
        chk_state("ld10", 4'd9, 1'b0, 1'b1);
        d = 4'd9;
        tick();
        chk_state("ld9", 4'd9, 1'b0, 1'b0);

        // tc is gated by en and reacts without a clock edge.
        en   = 1'b0;
        mode = MODE_UP;
        #1;
        chk("tc_gated", 16'(tc), 16'd0);
        en = 1'b1;
        #1;
        chk("tc_live", 16'(tc), 16'd1);

        // en=0 holds q at 4 over five edges.
        mode = MODE_LOAD;
        d    = 4'd4;
        tick();
        chk_state("ld4", 4'd4, 1'b0, 1'b0);
        en   = 1'b0;
        mode = MODE_UP;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state($sformatf("en0_%0d", i), 4'd4, 1'b0, 1'b0);
            chk($sformatf("en0_%0d.tc", i), 16'(tc), 16'd0);
        end

        // mode=00 holds even with en=1.
        en   = 1'b1;
        mode = MODE_HOLD;
        tick();
        chk_state("hold", 4'd4, 1'b0, 1'b0);

        // Counting at 5, reset between edges clears immediately.
        mode = MODE_UP;
        tick();
        chk_state("cnt5", 4'd5, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_state("mid_rst", 4'd0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        tick();
        chk_state("resume1", 4'd1, 1'b0, 1'b0);
        tick();
        chk_state("resume2", 4'd2, 1'b0, 1'b0);

        // Reset also clears a pending err pulse.
        mode = MODE_LOAD;
        d    = 4'd15;
        tick();
        chk_state("ld15", 4'd9, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_state("rst_err", 4'd0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        tick();
        chk_state("post_rst_ld", 4'd9, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_jk_counter
